// File: rtl/entrada_digitos_if.sv
// Key-entry bus between the keypad encoder side and the digit-entry stage.
`timescale 1ns/1ps
interface entrada_digitos_if;
  logic [7:0]  numero;
  logic        borrar;
  logic [15:0] digitos;
  logic [2:0]  cuenta;
  logic        lleno;
  logic        digito_valido;
  logic        desborde;

  modport master (
    output numero, borrar,
    input  digitos, cuenta, lleno, digito_valido, desborde
  );

  modport slave (
    input  numero, borrar,
    output digitos, cuenta, lleno, digito_valido, desborde
  );
endinterface

// File: rtl/entrada_digitos.sv
// Debounced digit entry: one accepted digit per physical key press, shifted
// into a 4-digit BCD register (newest digit in the low nibble).
`timescale 1ns/1ps
module entrada_digitos #(
  parameter int unsigned ESTABLE = 4
) (
  input  logic               clk,
  input  logic               reset,
  entrada_digitos_if.slave   bus
);

  typedef enum logic [1:0] {
    LIBRE         = 2'd0,
    ESTABILIZANDO = 2'd1,
    PRESIONADA    = 2'd2
  } estado_t;

  localparam logic [8:0] ESTABLE_W = 9'(ESTABLE);

  estado_t     state_reg, state_next;
  logic [3:0]  candidato_reg, candidato_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [15:0] digitos_reg, digitos_next;
  logic [2:0]  cuenta_reg, cuenta_next;
  logic        valido_reg, valido_next;
  logic        desborde_reg, desborde_next;

  logic       es_tecla;
  logic       coincide;
  logic       acepta;
  logic [8:0] cnt_inc;
  logic       cnt_llega;

  // Full 8-bit compare: codes like 8'h13 are "no key", not digit 3.
  assign es_tecla  = (bus.numero <= 8'd9);
  assign coincide  = (bus.numero == {4'd0, candidato_reg});
  assign cnt_inc   = {1'b0, cnt_reg} + 9'd1;
  assign cnt_llega = (cnt_inc >= ESTABLE_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= LIBRE;
      candidato_reg <= 4'hF;
      cnt_reg       <= 8'd0;
    end else begin
      state_reg     <= state_next;
      candidato_reg <= candidato_next;
      cnt_reg       <= cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    candidato_next = candidato_reg;
    cnt_next       = cnt_reg;
    acepta         = 1'b0;

    unique case (state_reg)
      LIBRE: begin
        if (es_tecla) begin
          candidato_next = bus.numero[3:0];
          cnt_next       = 8'd1;
          state_next     = ESTABILIZANDO;
        end
      end

      ESTABILIZANDO: begin
        if (coincide) begin
          if (cnt_llega) begin
            acepta     = 1'b1;
            cnt_next   = 8'd0;
            state_next = PRESIONADA;
          end else begin
            cnt_next = cnt_inc[7:0];
          end
        end else if (es_tecla) begin
          candidato_next = bus.numero[3:0];
          cnt_next       = 8'd1;
        end else begin
          cnt_next   = 8'd0;
          state_next = LIBRE;
        end
      end

      PRESIONADA: begin
        // Any key while held (even a different one) restarts the release count.
        if (es_tecla) begin
          cnt_next = 8'd0;
        end else if (cnt_llega) begin
          cnt_next   = 8'd0;
          state_next = LIBRE;
        end else begin
          cnt_next = cnt_inc[7:0];
        end
      end

      default: begin
        cnt_next   = 8'd0;
        state_next = LIBRE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digitos_reg  <= 16'h0000;
      cuenta_reg   <= 3'd0;
      valido_reg   <= 1'b0;
      desborde_reg <= 1'b0;
    end else begin
      digitos_reg  <= digitos_next;
      cuenta_reg   <= cuenta_next;
      valido_reg   <= valido_next;
      desborde_reg <= desborde_next;
    end
  end

  // Clear wins over a same-edge accept; the FSM is left alone so a held key
  // does not re-enter after the clear.
  always_comb begin
    digitos_next  = digitos_reg;
    cuenta_next   = cuenta_reg;
    valido_next   = 1'b0;
    desborde_next = 1'b0;

    if (bus.borrar) begin
      digitos_next = 16'h0000;
      cuenta_next  = 3'd0;
    end else if (acepta) begin
      if (cuenta_reg < 3'd4) begin
        digitos_next = {digitos_reg[11:0], candidato_reg};
        cuenta_next  = cuenta_reg + 3'd1;
        valido_next  = 1'b1;
      end else begin
        desborde_next = 1'b1;
      end
    end
  end

  assign bus.digitos       = digitos_reg;
  assign bus.cuenta        = cuenta_reg;
  assign bus.lleno         = (cuenta_reg == 3'd4);
  assign bus.digito_valido = valido_reg;
  assign bus.desborde      = desborde_reg;

endmodule

// File: tb/tb_entrada_digitos.sv
// Randomized + directed bench for entrada_digitos with a run-length reference
// model and a pulse scoreboard drained by an independent monitor.
`timescale 1ns/1ps
module tb_entrada_digitos;

  localparam int ESTABLE = 4;

  logic clk;
  logic reset;
  entrada_digitos_if bus_i ();

  entrada_digitos #(.ESTABLE(ESTABLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          ovf;
    logic [15:0] dig;
    int          cnt;
  } evento_t;

  evento_t     cola[$];
  int          checks   = 0;
  int          failures = 0;

  // Model: length of the current run of identical samples ("none" collapsed
  // to -1) and whether the key has been released long enough to re-arm.
  int          m_last;
  int          m_run;
  bit          m_armed;
  logic [15:0] m_dig;
  int          m_cnt;

  task automatic model_reset();
    m_last  = -1;
    m_run   = 0;
    m_armed = 1'b1;
    m_dig   = 16'h0000;
    m_cnt   = 0;
  endtask

  task automatic model_step(input logic [7:0] n, input logic b);
    int      code;
    bit      acc;
    evento_t e;
    code = (n <= 8'd9) ? int'(n) : -1;
    acc  = 1'b0;
    if (code == m_last) m_run++;
    else begin
      m_last = code;
      m_run  = 1;
    end
    if (code == -1) begin
      if (m_run >= ESTABLE) m_armed = 1'b1;
    end else if (m_armed && m_run == ESTABLE) begin
      acc     = 1'b1;
      m_armed = 1'b0;
    end
    if (b) begin
      m_dig = 16'h0000;
      m_cnt = 0;
    end else if (acc) begin
      if (m_cnt < 4) begin
        m_dig = (m_dig << 4) | 16'(code);
        m_cnt++;
        e.ovf = 1'b0;
      end else begin
        e.ovf = 1'b1;
      end
      e.dig = m_dig;
      e.cnt = m_cnt;
      cola.push_back(e);
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic ciclo(input logic [7:0] n, input logic b, input int veces);
    repeat (veces) begin
      bus_i.numero = n;
      bus_i.borrar = b;
      @(posedge clk);
      model_step(n, b);
      #1;
    end
  endtask

  task automatic pulsar(input logic [7:0] d);
    ciclo(d, 1'b0, 5);
    ciclo(8'd10, 1'b0, 5);
  endtask

  task automatic limpiar();
    ciclo(8'd10, 1'b1, 1);
    ciclo(8'd10, 1'b0, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_digitos"},  int'(bus_i.digitos), 0);
    chk({tag, "_cuenta"},   int'(bus_i.cuenta), 0);
    chk({tag, "_lleno"},    int'(bus_i.lleno), 0);
    chk({tag, "_valido"},   int'(bus_i.digito_valido), 0);
    chk({tag, "_desborde"}, int'(bus_i.desborde), 0);
  endtask

  // Monitor: state compared every cycle; pulses matched against the queue.
  always @(negedge clk) begin
    evento_t e;
    chk("mon_digitos", int'(bus_i.digitos), int'(m_dig));
    chk("mon_cuenta",  int'(bus_i.cuenta), m_cnt);
    chk("mon_lleno",   int'(bus_i.lleno), (m_cnt == 4) ? 1 : 0);
    chk("mon_pulsos_exclusivos", int'(bus_i.digito_valido & bus_i.desborde), 0);
    if (cola.size() > 0) begin
      e = cola.pop_front();
      chk("sb_valido",   int'(bus_i.digito_valido), e.ovf ? 0 : 1);
      chk("sb_desborde", int'(bus_i.desborde), e.ovf ? 1 : 0);
      chk("sb_digitos",  int'(bus_i.digitos), int'(e.dig));
      chk("sb_cuenta",   int'(bus_i.cuenta), e.cnt);
      $display("tx t=%0t %s digitos=%h cuenta=%0d", $time,
               e.ovf ? "desborde" : "digito", bus_i.digitos, bus_i.cuenta);
    end else begin
      chk("sb_pulso_inesperado",
          int'(bus_i.digito_valido | bus_i.desborde), 0);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    reset        = 1'b1;
    bus_i.numero = 8'd10;
    bus_i.borrar = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset_inicial");
    reset = 1'b0;

    // Single press of 7
    ciclo(8'd7, 1'b0, 6);
    ciclo(8'd10, 1'b0, 6);
    chk("unica_digitos", int'(bus_i.digitos), 16'h0007);
    chk("unica_cuenta",  int'(bus_i.cuenta), 1);

    // Bounce
    limpiar();
    ciclo(8'd3, 1'b0, 1);  ciclo(8'd10, 1'b0, 1);
    ciclo(8'd3, 1'b0, 2);  ciclo(8'd10, 1'b0, 1);
    ciclo(8'd3, 1'b0, 4);  ciclo(8'd10, 1'b0, 5);
    chk("rebote_digitos", int'(bus_i.digitos), 16'h0003);
    chk("rebote_cuenta",  int'(bus_i.cuenta), 1);

    // Four digits then overflow
    limpiar();
    pulsar(8'd1); pulsar(8'd2); pulsar(8'd3); pulsar(8'hFF - 8'd251);
    chk("lleno_digitos", int'(bus_i.digitos), 16'h1234);
    chk("lleno_flag",    int'(bus_i.lleno), 1);
    pulsar(8'd5);
    chk("desborde_digitos", int'(bus_i.digitos), 16'h1234);
    chk("desborde_cuenta",  int'(bus_i.cuenta), 4);

    // Rollover
    limpiar();
    ciclo(8'd5, 1'b0, 4);
    ciclo(8'd6, 1'b0, 10);
    ciclo(8'hC8, 1'b0, 6);
    chk("rollover_digitos", int'(bus_i.digitos), 16'h0005);
    chk("rollover_cuenta",  int'(bus_i.cuenta), 1);

    // Clear on the exact accept edge
    limpiar();
    pulsar(8'd1); pulsar(8'd2);
    chk("colision_previo", int'(bus_i.digitos), 16'h0012);
    ciclo(8'd9, 1'b0, 3);
    ciclo(8'd9, 1'b1, 1);
    ciclo(8'd9, 1'b0, 8);
    chk("colision_digitos", int'(bus_i.digitos), 16'h0000);
    chk("colision_cuenta",  int'(bus_i.cuenta), 0);
    ciclo(8'd10, 1'b0, 5);

    // Asynchronous reset mid-press
    pulsar(8'd8); pulsar(8'd9);
    chk("reset_previo", int'(bus_i.digitos), 16'h0089);
    ciclo(8'd4, 1'b0, 2);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 chk_reset_outputs("reset_async");
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ciclo(8'd4, 1'b0, 8);
    ciclo(8'd10, 1'b0, 5);
    chk("reset_tras_digitos", int'(bus_i.digitos), 16'h0004);
    chk("reset_tras_cuenta",  int'(bus_i.cuenta), 1);

    // Random traffic
    limpiar();
    for (int i = 0; i < 400; i++) begin
      logic [7:0] n;
      logic       b;
      if ($urandom_range(0, 9) < 6) n = 8'($urandom_range(0, 9));
      else                          n = 8'($urandom_range(10, 255));
      b = ($urandom_range(0, 29) == 0);
      ciclo(n, b, int'($urandom_range(1, 8)));
    end

    ciclo(8'd10, 1'b0, 3);
    chk("cola_vacia", cola.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
